// File: rtl/md_pkg.sv
// Shared encodings and helpers for the EX-stage multiply/divide unit.
// Holds op codes, FSM state codes and op-class decode functions.
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  // Iterative ops: MULT, MULTU, DIV, DIVU.
  function automatic logic is_md_arith(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd4);
  endfunction

  // Any op that touches HI/LO (depends on an in-flight result).
  function automatic logic is_md_hilo(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd8);
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// Iterative radix-2 multiply / restoring divide datapath with sign fix-up.
// Ports: clk, i_reset, i_step, i_start (latch operands), i_run (iterate),
// i_div, i_signed, i_a, i_b -> o_last (final iteration), o_hi/o_lo (fixed).
import md_pkg::*;

module md_iter_core #(
  parameter int NB_DATA = 32,
  parameter int NB_CNT  = $clog2(NB_DATA) + 1
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_step,
  input  logic               i_start,
  input  logic               i_run,
  input  logic               i_div,
  input  logic               i_signed,
  input  logic [NB_DATA-1:0] i_a,
  input  logic [NB_DATA-1:0] i_b,
  output logic               o_last,
  output logic [NB_DATA-1:0] o_hi,
  output logic [NB_DATA-1:0] o_lo
);

  localparam int N = NB_DATA;

  logic [2*N-1:0]    prod_q, prod_d;
  logic [N-1:0]      opnd_q;
  logic [NB_CNT-1:0] cnt_q;
  logic              div_q;
  logic              pneg_q;
  logic              rneg_q;

  logic [N-1:0] abs_a, abs_b;
  logic         b_zero;
  logic         neg_res;
  logic         neg_rem;

  // Operand magnitudes and sign bookkeeping at issue.
  always_comb begin
    abs_a   = (i_signed && i_a[N-1]) ? -i_a : i_a;
    abs_b   = (i_signed && i_b[N-1]) ? -i_b : i_b;
    b_zero  = ~|i_b;
    // Divide by zero keeps the all-ones quotient unsigned.
    neg_res = i_signed & (i_a[N-1] ^ i_b[N-1])
            & ~(i_div & b_zero);
    neg_rem = i_signed & i_a[N-1] & i_div;
  end

  logic [N:0]   mul_sum;
  logic [N:0]   rem_sh;
  logic [N-1:0] rem_df;
  logic         rem_ge;

  // One iteration step of either operation.
  always_comb begin
    mul_sum = {1'b0, prod_q[2*N-1:N]}
            + (prod_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh  = {prod_q[2*N-1:N], prod_q[N-1]};
    rem_ge  = rem_sh >= {1'b0, opnd_q};
    rem_df  = rem_sh[N-1:0] - opnd_q;
    if (div_q) begin
      prod_d = rem_ge
             ? {rem_df, prod_q[N-2:0], 1'b1}
             : {rem_sh[N-1:0], prod_q[N-2:0], 1'b0};
    end else begin
      prod_d = {mul_sum, prod_q[N-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      prod_q <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
      pneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else if (i_step) begin
      if (i_start) begin
        prod_q <= {{N{1'b0}}, (i_div ? abs_a : abs_b)};
        opnd_q <= i_div ? abs_b : abs_a;
        cnt_q  <= NB_CNT'(N);
        div_q  <= i_div;
        pneg_q <= neg_res;
        rneg_q <= neg_rem;
      end else if (i_run) begin
        prod_q <= prod_d;
        cnt_q  <= cnt_q - NB_CNT'(1);
      end
    end
  end

  assign o_last = (cnt_q == NB_CNT'(1));

  logic [2*N-1:0] prod_fix;
  logic [N-1:0]   quo, rem;

  // Sign correction on the finished magnitude result.
  always_comb begin
    prod_fix = pneg_q ? -prod_q : prod_q;
    quo      = pneg_q ? -prod_q[N-1:0] : prod_q[N-1:0];
    rem      = rneg_q ? -prod_q[2*N-1:N]
                      : prod_q[2*N-1:N];
    if (div_q) begin
      o_hi = rem;
      o_lo = quo;
    end else begin
      o_hi = prod_fix[2*N-1:N];
      o_lo = prod_fix[N-1:0];
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multi-cycle multiply/divide unit with HI/LO registers.
// Ports: clk, i_reset, i_step, i_md_op, i_data_A/B -> o_busy, o_stall,
// o_md_result (MFHI/MFLO data), o_hi, o_lo.
import md_pkg::*;

module ex_muldiv_unit #(
  parameter int NB_DATA = 32,
  parameter int NB_OP   = 4,
  parameter int NB_CNT  = $clog2(NB_DATA) + 1
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_step,
  input  logic [NB_OP-1:0]   i_md_op,
  input  logic [NB_DATA-1:0] i_data_A,
  input  logic [NB_DATA-1:0] i_data_B,
  output logic               o_busy,
  output logic               o_stall,
  output logic [NB_DATA-1:0] o_md_result,
  output logic [NB_DATA-1:0] o_hi,
  output logic [NB_DATA-1:0] o_lo
);

  md_state_e          state_q;
  logic [NB_DATA-1:0] hi_q, lo_q;
  logic [3:0]         op;
  logic               issue;
  logic               is_div;
  logic               is_sgn;
  logic               core_last;
  logic [NB_DATA-1:0] core_hi, core_lo;

  assign op      = i_md_op[3:0];
  assign o_busy  = (state_q != ST_IDLE);
  assign o_stall = o_busy && is_md_hilo(op);
  assign issue   = (state_q == ST_IDLE)
                && is_md_arith(op);
  assign is_div  = (op == MD_DIV) || (op == MD_DIVU);
  assign is_sgn  = (op == MD_MULT) || (op == MD_DIV);

  md_iter_core #(
    .NB_DATA (NB_DATA),
    .NB_CNT  (NB_CNT)
  ) u_core (
    .clk      (clk),
    .i_reset  (i_reset),
    .i_step   (i_step),
    .i_start  (issue),
    .i_run    (state_q == ST_ITER),
    .i_div    (is_div),
    .i_signed (is_sgn),
    .i_a      (i_data_A),
    .i_b      (i_data_B),
    .o_last   (core_last),
    .o_hi     (core_hi),
    .o_lo     (core_lo)
  );

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (i_step) begin
      unique case (state_q)
        ST_IDLE: begin
          if (issue)
            state_q <= ST_ITER;
          else if (op == MD_MTHI)
            hi_q <= i_data_A;
          else if (op == MD_MTLO)
            lo_q <= i_data_A;
        end
        ST_ITER: begin
          if (core_last)
            state_q <= ST_FIX;
        end
        ST_FIX: begin
          state_q <= ST_IDLE;
          hi_q    <= core_hi;
          lo_q    <= core_lo;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_md_result = '0;
    unique case (1'b1)
      (op == MD_MFHI): o_md_result = hi_q;
      (op == MD_MFLO): o_md_result = lo_q;
      default:         o_md_result = '0;
    endcase
  end

  assign o_hi = hi_q;
  assign o_lo = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit (NB_DATA=32).
// Expected values are hand-computed constants.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        step;
  logic [3:0]  md_op;
  logic [31:0] data_a, data_b;
  logic        busy, stall;
  logic [31:0] md_res, hi, lo;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit dut (
    .clk         (clk),
    .i_reset     (rst),
    .i_step      (step),
    .i_md_op     (md_op),
    .i_data_A    (data_a),
    .i_data_B    (data_b),
    .o_busy      (busy),
    .o_stall     (stall),
    .o_md_result (md_res),
    .o_hi        (hi),
    .o_lo        (lo)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic run_arith(input logic [3:0] op,
                           input logic [31:0] a,
                           input logic [31:0] b,
                           input logic [31:0] ehi,
                           input logic [31:0] elo,
                           input string tag);
    int n;
    md_op  = op;
    data_a = a;
    data_b = b;
    tick();
    md_op = 4'd0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    wait_idle(n);
    chk({tag, "_lat"}, 64'(n), 64'd33);
    chk({tag, "_hi"}, 64'(hi), 64'(ehi));
    chk({tag, "_lo"}, 64'(lo), 64'(elo));
  endtask

  initial begin
    int n;
    rst    = 1'b1;
    step   = 1'b1;
    md_op  = 4'd0;
    data_a = '0;
    data_b = '0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_res", 64'(md_res), 64'd0);

    run_arith(4'd1, 32'hFFFF_FFFD, 32'd5,
              32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult");
    run_arith(4'd4, 32'd100, 32'd7,
              32'd2, 32'd14, "divu");
    run_arith(4'd3, 32'hFFFF_FFF9, 32'd2,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
    run_arith(4'd3, 32'h8000_0000, 32'd0,
              32'h8000_0000, 32'hFFFF_FFFF, "div_z");
    run_arith(4'd3, 32'h8000_0000, 32'hFFFF_FFFF,
              32'd0, 32'h8000_0000, "div_ovf");

    // MULTU with a dependent MFLO three cycles later.
    md_op  = 4'd2;
    data_a = 32'hFFFF_FFFF;
    data_b = 32'hFFFF_FFFF;
    tick();
    md_op = 4'd0;
    #1;
    chk("add_nostall", 64'(stall), 64'd0);
    tick();
    tick();
    md_op = 4'd6;
    #1;
    chk("mflo_stall", 64'(stall), 64'd1);
    n = 0;
    while (stall && n < 200) begin
      tick();
      n++;
    end
    chk("mflo_wait", 64'(n), 64'd31);
    chk("mflo_nostall", 64'(stall), 64'd0);
    chk("mflo_res", 64'(md_res), 64'd1);
    md_op = 4'd5;
    #1;
    chk("mfhi_res", 64'(md_res), 64'hFFFF_FFFE);
    md_op = 4'd0;
    tick();

    // DIVU with i_step low for 10 cycles mid-iteration.
    md_op  = 4'd4;
    data_a = 32'd100;
    data_b = 32'd7;
    tick();
    md_op = 4'd0;
    n = 0;
    repeat (5) begin
      tick();
      n++;
    end
    step = 1'b0;
    repeat (10) begin
      tick();
      n++;
    end
    chk("frz_busy", 64'(busy), 64'd1);
    chk("frz_hi", 64'(hi), 64'hFFFF_FFFE);
    step = 1'b1;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk("frz_lat", 64'(n), 64'd43);
    chk("frz_hi_done", 64'(hi), 64'd2);
    chk("frz_lo_done", 64'(lo), 64'd14);

    // Reset in the middle of a MULT.
    md_op  = 4'd1;
    data_a = 32'd6;
    data_b = 32'd7;
    tick();
    md_op = 4'd0;
    repeat (14) tick();
    chk("abort_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    repeat (25) tick();
    chk("abort_lo_late", 64'(lo), 64'd0);

    md_op  = 4'd7;
    data_a = 32'h1234;
    tick();
    chk("mthi", 64'(hi), 64'h1234);
    chk("mthi_lo", 64'(lo), 64'd0);
    md_op  = 4'd8;
    data_a = 32'h5678;
    tick();
    chk("mtlo", 64'(lo), 64'h5678);
    md_op = 4'd0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
